// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave and master state encodings plus a small majority helper.
package i2c_pkg;

  localparam int unsigned SlvStateW = 4;

  typedef enum logic [SlvStateW-1:0] {
    SlvIdle,
    SlvAddr,
    SlvAddrAck,
    SlvSub,
    SlvSubAck,
    SlvWdata,
    SlvWdataAck,
    SlvRdata,
    SlvRdataAck,
    SlvWaitStop
  } slv_state_e;

  localparam int unsigned MstStateW = 3;

  typedef enum logic [MstStateW-1:0] {
    MstIdle,
    MstStart,
    MstBit,
    MstAck,
    MstStop
  } mst_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA and reports SCL edges plus START/STOP conditions.
// Defining I2C_SLAVE_GLITCH_FILTER_EN inserts a 3-sample majority filter after the synchronizers.
module i2c_bus_monitor
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_f, sda_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_raw};
      sda_sync_q <= {sda_sync_q[0], sda_raw};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_f = scl_filt_q;
  assign sda_f = sda_filt_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  assign sda      = sda_f;
  assign scl_rise = scl_f & ~scl_prev_q;
  assign scl_fall = ~scl_f & scl_prev_q;
  // SDA may only move while SCL is high to signal START/STOP.
  assign start    = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop     = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave bridging bus transactions to a byte-wide register file with an auto-incrementing
// pointer. I2C_SLAVE_GLITCH_FILTER_EN enables SCL/SDA majority filtering in i2c_bus_monitor.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h4B,
  parameter logic [7:0] PTR_RST    = 8'h00
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       scl_i,
  inout  wire        sda_io,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       nack_seen
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_monitor u_mon (
    .clk      (i_clk),
    .rst      (reset),
    .scl_raw  (scl_i),
    .sda_raw  (sda_io),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  slv_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, ptr_q, ptr_d, wdata_q, wdata_d;
  logic       we_q, we_d, re_q, re_d, busy_q, busy_d, nack_q, nack_d;
  logic       oe_q, oe_d, mack_q, mack_d, cap_q, cap_d, rw_q, rw_d;
  logic [7:0] rx_byte;

  assign rx_byte = {rx_q[6:0], sda};

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q <= SlvIdle;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      ptr_q   <= PTR_RST;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      nack_q  <= 1'b0;
      oe_q    <= 1'b0;
      mack_q  <= 1'b0;
      cap_q   <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      nack_q  <= nack_d;
      oe_q    <= oe_d;
      mack_q  <= mack_d;
      cap_q   <= cap_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;
    nack_d  = 1'b0;
    oe_d    = oe_q;
    mack_d  = mack_q;
    rw_d    = rw_q;
    // Read data returns the cycle after the strobe; grab it one cycle later still.
    cap_d   = re_q;
    if (cap_q) tx_d = reg_rdata;
    if (we_q) ptr_d = ptr_q + 8'd1;

    if (stop) begin
      state_d = SlvIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      mack_d  = 1'b0;
    end else if (start) begin
      state_d = SlvAddr;
      cnt_d   = '0;
      oe_d    = 1'b0;
      mack_d  = 1'b0;
    end else begin
      unique case (state_q)
        SlvIdle, SlvWaitStop: ;
        SlvAddr, SlvSub, SlvWdata: begin
          if (scl_rise) begin
            rx_d  = rx_byte;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == SlvAddr) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = SlvAddrAck;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                  re_d    = rx_byte[0];
                end else begin
                  state_d = SlvWaitStop;
                end
              end else if (state_q == SlvSub) begin
                ptr_d   = rx_byte;
                state_d = SlvSubAck;
              end else begin
                we_d    = 1'b1;
                wdata_d = rx_byte;
                state_d = SlvWdataAck;
              end
            end
          end
        end
        SlvAddrAck, SlvSubAck, SlvWdataAck: begin
          // First fall drives the ACK, the second one ends the ACK clock.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = '0;
              if (state_q == SlvAddrAck && rw_q) begin
                state_d = SlvRdata;
                oe_d    = ~tx_q[7];
                tx_d    = {tx_q[6:0], 1'b0};
              end else if (state_q == SlvAddrAck) begin
                state_d = SlvSub;
              end else begin
                state_d = SlvWdata;
              end
            end
          end
        end
        SlvRdata: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              oe_d    = 1'b0;
              ptr_d   = ptr_q + 8'd1;
              mack_d  = 1'b0;
              state_d = SlvRdataAck;
            end else begin
              oe_d  = ~tx_q[7];
              tx_d  = {tx_q[6:0], 1'b0};
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        SlvRdataAck: begin
          if (scl_rise) begin
            if (!sda) begin
              mack_d = 1'b1;
              re_d   = 1'b1;
            end else begin
              nack_d  = 1'b1;
              state_d = SlvWaitStop;
            end
          end else if (scl_fall && mack_q) begin
            state_d = SlvRdata;
            cnt_d   = '0;
            mack_d  = 1'b0;
            oe_d    = ~tx_q[7];
            tx_d    = {tx_q[6:0], 1'b0};
          end
        end
        default: state_d = SlvIdle;
      endcase
    end
  end

  assign sda_io    = oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  assign nack_seen = nack_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bus-level master, register-file stub, scoreboard of strobes.
module tb_i2c_slave;

  localparam logic [6:0] Addr   = 7'h4B;
  localparam logic [7:0] PtrRst = 8'h00;
  localparam int         Q      = 6;
  localparam logic [1:0] EvWe   = 2'd0;
  localparam logic [1:0] EvRe   = 2'd1;
  localparam logic [1:0] EvNack = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       i_clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy, nack_seen;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  i2c_slave #(
    .SLAVE_ADDR (Addr),
    .PTR_RST    (PtrRst)
  ) dut (
    .i_clk     (i_clk),
    .reset     (reset),
    .scl_i     (scl),
    .sda_io    (sda_bus),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .nack_seen (nack_seen)
  );

  always #5 i_clk = ~i_clk;

  // Register-file stub: every location reads as its address plus 0x10.
  always_ff @(posedge i_clk) if (reg_re) reg_rdata <= reg_addr + 8'h10;

  int         checks = 0;
  int         failures = 0;
  ev_t        exp_q[$];
  logic [7:0] mptr = PtrRst;
  logic [7:0] wbytes[$];
  logic       watch_nd = 1'b0;
  int         stray = 0;
  int         busy_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: any strobe from the DUT must match the oldest expected event.
  ev_t act_ev, exp_ev;
  always @(negedge i_clk) begin
    if (!reset && (reg_we || reg_re || nack_seen)) begin
      act_ev.kind = reg_we ? EvWe : (reg_re ? EvRe : EvNack);
      act_ev.addr = nack_seen ? 8'h00 : reg_addr;
      act_ev.data = reg_we ? reg_wdata : 8'h00;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe act=%0h exp=none", act_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        check("strobe", 32'(act_ev), 32'(exp_ev));
      end
    end
  end

  always @(negedge i_clk) begin
    if (watch_nd) begin
      if (!m_low && sda_bus == 1'b0) stray++;
      if (busy) busy_hi++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_start();
    m_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic send_stop();
    m_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    m_low = ~b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    if (glitch) begin
      scl = 1'b0;
      wait_clk(1);
      scl = 1'b1;
    end
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    b = sda_bus;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name,
                            input int glitch_bit);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(b[i], i == glitch_bit);
    read_bit(a);
    check(name, 32'(a), 32'(exp_ack));
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    write_bit(~mack, 1'b0);
  endtask

  // Write transaction: sub-address then the bytes queued in wbytes.
  task automatic txn_write(input logic [6:0] a7, input logic [7:0] sub, input int glitch_bit);
    logic match;
    match = (a7 == Addr);
    if (!match) begin
      stray   = 0;
      busy_hi = 0;
      watch_nd = 1'b1;
    end
    send_start();
    write_byte({a7, 1'b0}, ~match, "addr_ack", -1);
    if (match) check("busy_on_match", 32'(busy), 32'd1);
    write_byte(sub, ~match, "sub_ack", -1);
    if (match) mptr = sub;
    foreach (wbytes[k]) begin
      if (match) exp_q.push_back('{kind: EvWe, addr: mptr, data: wbytes[k]});
      write_byte(wbytes[k], ~match, "data_ack", (k == 0) ? glitch_bit : -1);
      if (match) mptr = mptr + 8'd1;
    end
    send_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    if (!match) begin
      watch_nd = 1'b0;
      check("mismatch_sda_driven", 32'(stray), 32'd0);
      check("mismatch_busy", 32'(busy_hi), 32'd0);
    end
  endtask

  // Pointer write, repeated START, then n reads (ACK all but the last).
  task automatic txn_read(input logic [7:0] sub, input int n);
    logic [7:0] b;
    send_start();
    write_byte({Addr, 1'b0}, 1'b0, "raddr_w_ack", -1);
    write_byte(sub, 1'b0, "rsub_ack", -1);
    mptr = sub;
    send_start();
    exp_q.push_back('{kind: EvRe, addr: mptr, data: 8'h00});
    write_byte({Addr, 1'b1}, 1'b0, "raddr_r_ack", -1);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) exp_q.push_back('{kind: EvNack, addr: 8'h00, data: 8'h00});
      else exp_q.push_back('{kind: EvRe, addr: mptr + 8'd1, data: 8'h00});
      read_byte(b, k != n - 1);
      check("rdata", 32'(b), 32'(mptr + 8'h10));
      mptr = mptr + 8'd1;
    end
    send_stop();
    check("busy_after_rstop", 32'(busy), 32'd0);
  endtask

  initial begin
    logic       v;
    logic [6:0] ra;
    int         n;

    wait_clk(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_re", 32'(reg_re), 32'd0);
    check("rst_nack", 32'(nack_seen), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'(PtrRst));
    check("rst_wdata", 32'(reg_wdata), 32'd0);
    check("rst_sda", 32'(sda_bus), 32'd1);
    reset = 1'b0;
    wait_clk(4);

    wbytes = '{8'hAB, 8'hCD};
    txn_write(Addr, 8'h03, -1);

    txn_read(8'h00, 2);

    wbytes = '{8'h55, 8'hAA};
    txn_write(7'h48, 8'h12, -1);

    wbytes = '{8'h11, 8'h22};
    txn_write(Addr, 8'hFF, -1);

    // Reset mid-byte while the slave is driving data bits of 0x10.
    send_start();
    write_byte({Addr, 1'b0}, 1'b0, "rt_w_ack", -1);
    write_byte(8'h00, 1'b0, "rt_sub_ack", -1);
    send_start();
    exp_q.push_back('{kind: EvRe, addr: 8'h00, data: 8'h00});
    write_byte({Addr, 1'b1}, 1'b0, "rt_r_ack", -1);
    read_bit(v);
    check("rt_bit7", 32'(v), 32'd0);
    check("rt_slave_drives", 32'(sda_bus), 32'd0);
    @(negedge i_clk);
    reset = 1'b1;
    #1;
    check("rt_sda_released", 32'(sda_bus), 32'd1);
    check("rt_busy", 32'(busy), 32'd0);
    check("rt_ptr", 32'(reg_addr), 32'(PtrRst));
    wait_clk(2);
    reset = 1'b0;
    mptr = PtrRst;
    for (int i = 0; i < 7; i++) begin
      read_bit(v);
      check("rt_ignored", 32'(v), 32'd1);
    end
    write_bit(1'b1, 1'b0);
    send_stop();
    wbytes = '{8'h5A};
    txn_write(Addr, 8'h40, -1);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    wbytes = '{8'hC3, 8'h3C};
    txn_write(Addr, 8'h20, 4);
`endif

    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(1, 3);
      case ($urandom_range(0, 2))
        0: begin
          wbytes = {};
          for (int k = 0; k < n; k++) wbytes.push_back(8'($urandom_range(0, 255)));
          txn_write(Addr, 8'($urandom_range(0, 255)), -1);
        end
        1: txn_read(8'($urandom_range(0, 255)), n);
        default: begin
          ra = 7'($urandom_range(0, 127));
          if (ra == Addr) ra = ra ^ 7'h01;
          wbytes = '{8'($urandom_range(0, 255))};
          txn_write(ra, 8'($urandom_range(0, 255)), -1);
        end
      endcase
    end

    wait_clk(10);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h4B, 7-bit bus address to which the block responds.
REQ-002 SHALL have parameter PTR_RST, default 8'h00, register pointer value after reset.
REQ-003 SHALL have port i_clk, input, 1, system clock (100 MHz, at least 20x SCL rate).
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port scl_i, input, 1, I2C clock line (never driven; no clock stretching).
REQ-006 SHALL have port sda_io, inout, 1, I2C data line; driven only to 1'b0, otherwise 1'bz.
REQ-007 SHALL have port reg_addr, output, 8, register pointer presented to the register file.
REQ-008 SHALL have port reg_wdata, output, 8, byte received from the master.
REQ-009 SHALL have port reg_we, output, 1, one-cycle write strobe qualifying reg_addr/reg_wdata.
REQ-010 SHALL have port reg_re, output, 1, one-cycle read strobe; reg_rdata is valid the following cycle.
REQ-011 SHALL have port reg_rdata, input, 8, read data from the register file.
REQ-012 SHALL have port busy, output, 1, high from an address match until STOP.
REQ-013 SHALL have port nack_seen, output, 1, one-cycle pulse when the master NACKs a read byte.

Function
REQ-014 SHALL pass scl_i and sda_io through 2-flop synchronizers; all edge detection SHALL use synchronized values.
REQ-015 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-016 SHALL sample SDA on the synchronized SCL rising edge and change the driven SDA only on the synchronized SCL falling edge.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-018 START in any state SHALL go to ADDR with bit counter cleared; STOP in any state SHALL go to IDLE, release SDA and clear busy.
REQ-019 ADDR SHALL shift 8 bits MSB first; on match with R/W=0 it SHALL ACK and go to SUB; on match with R/W=1 it SHALL ACK, pulse reg_re, and go to RDATA; on mismatch it SHALL go to WAIT_STOP without driving SDA.
REQ-020 SUB SHALL load the received byte into the pointer and ACK; following bytes SHALL go to WDATA.
REQ-021 WDATA SHALL ACK each byte, pulse reg_we with reg_addr=pointer and reg_wdata=byte, then increment the pointer.
REQ-022 RDATA SHALL transmit the byte captured from reg_rdata MSB first, then release SDA for the master ACK; the pointer SHALL increment after each byte.
REQ-023 Master ACK in RDATA_ACK SHALL pulse reg_re and continue to RDATA; master NACK SHALL pulse nack_seen and go to WAIT_STOP.
REQ-024 Pointer arithmetic SHALL be 8-bit modulo: 8'hFF increments to 8'h00.
REQ-025 A repeated START after SUB SHALL keep the pointer, so that a write-pointer/read sequence reads from the new pointer.
REQ-026 START and STOP detected in the same cycle as a data edge SHALL take priority over the data edge.

Reset
REQ-027 Reset SHALL force state=IDLE, sda_io=1'bz, pointer=PTR_RST, reg_addr=PTR_RST, reg_wdata=0, reg_we=0, reg_re=0, busy=0, nack_seen=0, and synchronizers to 1.
REQ-028 Reset asserted mid-transaction SHALL release SDA within the same cycle, and the block SHALL ignore the bus until the next START.

Configuration
REQ-029 When I2C_SLAVE_GLITCH_FILTER_EN is defined, SCL and SDA SHALL each pass through a 3-sample majority filter after synchronization, adding 2 cycles of latency.
REQ-030 When I2C_SLAVE_GLITCH_FILTER_EN is undefined, the synchronizer outputs SHALL be used directly.

Structure
REQ-031 The state encoding type and the state width constant SHALL reside in the shared package i2c_pkg, together with the master's definitions.
REQ-032 START/STOP/edge detection, including the optional filter, SHALL be a sub-module named i2c_bus_monitor.

Verification
REQ-033 Bench SHALL cover: write 0x96, sub 0x03, data 0xAB, 0xCD -> reg_we pulses at addr 0x03=0xAB and 0x04=0xCD; every ACK is low.
REQ-034 Bench SHALL cover: write 0x96, sub 0x00, repeated START, 0x97, read 2 bytes with reg_rdata=addr+0x10, ACK then NACK -> SDA carries 0x10 then 0x11; one nack_seen pulse.
REQ-035 Bench SHALL cover: address 0x90 -> SDA is never driven; busy stays 0; no strobes.
REQ-036 Bench SHALL cover: sub 0xFF, write 2 bytes -> reg_we at 0xFF and then at 0x00.
REQ-037 Bench SHALL cover: reset pulsed mid-byte during RDATA -> sda_io=z the same cycle, state=IDLE, and the next transaction completes normally.
REQ-038 Bench SHALL cover: with I2C_SLAVE_GLITCH_FILTER_EN defined, a 1-cycle SCL glitch during WDATA -> no extra bit is shifted and the received byte is correct.
